// File: rtl/nios_system_nios2_cpu_mul_pkg.sv
// Shared constants, op encodings, state enum and word-assembly helpers for the
// Nios II multiply combine stage.
package nios_system_nios2_cpu_mul_pkg;

  localparam int HALF_W       = 16;
  localparam int HH_ITERS_DEF = 16;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULXUU = 2'b01;
  localparam logic [1:0] MUL_OP_MULXSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULXSS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HH_RUN = 2'd1,
    ST_HI_FIX = 2'd2,
    ST_DONE   = 2'd3
  } mul_state_e;

  // The cross-product sum keeps its carry; dropping bit 32 breaks 0xFFFFFFFF^2.
  function automatic logic [32:0] mid_sum(input logic [31:0] p2, input logic [31:0] p3);
    return {1'b0, p2} + {1'b0, p3};
  endfunction

  function automatic logic [31:0] lo_word(input logic [31:0] p1, input logic [32:0] mid);
    return p1 + {mid[15:0], 16'h0000};
  endfunction

  function automatic logic [31:0] hi_uu_word(input logic [31:0] hh, input logic [31:0] p1,
                                             input logic [32:0] mid);
    logic [63:0] full;
    full = {hh, 32'h0} + {15'h0, mid, 16'h0} + {32'h0, p1};
    return full[63:32];
  endfunction

endpackage

// File: rtl/nios_system_nios2_cpu_mul_hh_seq.sv
// Unsigned 16x16 shift-add sequencer: one multiplier bit per cycle, done pulses
// for one cycle after the last iteration while product_o holds until next start.
module nios_system_nios2_cpu_mul_hh_seq
  import nios_system_nios2_cpu_mul_pkg::*;
#(
  parameter int ITERS = HH_ITERS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [HALF_W-1:0]     a_i,
  input  logic [HALF_W-1:0]     b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2*HALF_W-1:0]   product_o
);

  localparam int CW = $clog2(ITERS) + 1;

  logic [HALF_W-1:0]   a_q, b_q;
  logic [2*HALF_W-1:0] acc_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q, done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      if (b_q[cnt_q[CW-2:0]])
        acc_q <= acc_q + ({{HALF_W{1'b0}}, a_q} << cnt_q);
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(ITERS - 1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/nios_system_nios2_cpu_mul_combine.sv
// Combines registered 16x16 partial products into the 32-bit A-stage result.
// NIOS2_MULX_EN enables the multi-cycle MULX high-word path; otherwise all ops are MUL.
module nios_system_nios2_cpu_mul_combine
  import nios_system_nios2_cpu_mul_pkg::*;
#(
  parameter int HH_ITERS = HH_ITERS_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  input  logic [31:0] M_src1,
  input  logic [31:0] M_src2,
  input  logic        M_mul_valid,
  input  logic [1:0]  M_mul_op,
  input  logic        A_en,
  output logic [31:0] A_mul_result,
  output logic        A_mul_done,
  output logic        M_mul_stall
);

  logic [32:0] mid_w;
  logic [31:0] lo_w;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        accept_w;

  assign mid_w = mid_sum(M_mul_cell_p2, M_mul_cell_p3);
  assign lo_w  = lo_word(M_mul_cell_p1, mid_w);

`ifdef NIOS2_MULX_EN
  mul_state_e  state_q, state_d;
  logic [31:0] p1_q, p2_q, p3_q, src1_q, src2_q;
  logic [1:0]  op_q;
  logic        seq_start_w, seq_busy_w, seq_done_w;
  logic [31:0] hh_w, hi_w;
  logic [32:0] mid_q_w;

  assign M_mul_stall = (state_q != ST_IDLE) | (done_q & ~A_en);
  assign accept_w    = M_mul_valid & ~M_mul_stall;
  assign seq_start_w = accept_w & (M_mul_op != MUL_OP_MUL);

  nios_system_nios2_cpu_mul_hh_seq #(.ITERS(HH_ITERS)) u_hh_seq (
    .clk       (clk),
    .rst_n     (reset_n),
    .start_i   (seq_start_w),
    .a_i       (M_src1[31:16]),
    .b_i       (M_src2[31:16]),
    .busy_o    (seq_busy_w),
    .done_o    (seq_done_w),
    .product_o (hh_w)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_q   <= '0;
      p2_q   <= '0;
      p3_q   <= '0;
      src1_q <= '0;
      src2_q <= '0;
      op_q   <= MUL_OP_MUL;
    end else if (seq_start_w) begin
      p1_q   <= M_mul_cell_p1;
      p2_q   <= M_mul_cell_p2;
      p3_q   <= M_mul_cell_p3;
      src1_q <= M_src1;
      src2_q <= M_src2;
      op_q   <= M_mul_op;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (seq_start_w) state_d = ST_HH_RUN;
      ST_HH_RUN: if (seq_done_w & ~seq_busy_w) state_d = ST_HI_FIX;
      ST_HI_FIX: state_d = ST_DONE;
      ST_DONE:   if (A_en) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Two's-complement correction: a negative operand contributes -other<<32.
  always_comb begin
    mid_q_w = mid_sum(p2_q, p3_q);
    hi_w    = hi_uu_word(hh_w, p1_q, mid_q_w);
    if ((op_q != MUL_OP_MULXUU) && src1_q[31]) hi_w = hi_w - src2_q;
    if ((op_q == MUL_OP_MULXSS) && src2_q[31]) hi_w = hi_w - src1_q;
  end

  always_comb begin
    result_d = result_q;
    done_d   = done_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_w && (M_mul_op == MUL_OP_MUL)) begin
          result_d = lo_w;
          done_d   = 1'b1;
        end else if (A_en) begin
          done_d = 1'b0;
        end
      end
      ST_HI_FIX: begin
        result_d = hi_w;
        done_d   = 1'b1;
      end
      ST_DONE: if (A_en) done_d = 1'b0;
      default: ;
    endcase
  end
`else
  logic unused_ok;
  assign unused_ok = ^{M_mul_op, M_src1, M_src2};

  assign M_mul_stall = done_q & ~A_en;
  assign accept_w    = M_mul_valid & ~M_mul_stall;

  always_comb begin
    result_d = result_q;
    done_d   = done_q;
    if (accept_w) begin
      result_d = lo_w;
      done_d   = 1'b1;
    end else if (A_en) begin
      done_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign A_mul_result = result_q;
  assign A_mul_done   = done_q;

endmodule
